// File: rtl/calc_add_sequencer.sv
// Operand-SRAM walker that feeds word pairs through a ripple-carry adder and writes sums back.
// Optional sticky carry flag output enabled by defining CALC_SEQ_CARRY_FLAG_EN.

package calculator_pkg;
    localparam int DATA_W = 32;
endpackage

module adder32
    import calculator_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] sum_o
);
    // The chain stops at bit DATA_W-1; the carry-out is never needed downstream.
    logic [DATA_W-1:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < DATA_W; i++) begin : g_bit
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
        if (i < DATA_W - 1) begin : g_carry
            assign c[i+1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
    end
endmodule

module calc_add_sequencer
    import calculator_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] read_start_addr_i,
    input  logic [ADDR_W-1:0] read_end_addr_i,
    input  logic [ADDR_W-1:0] write_start_addr_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
`ifdef CALC_SEQ_CARRY_FLAG_EN
    ,
    output logic              carry_o
`endif
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD_A  = 3'd1,
        S_RD_B  = 3'd2,
        S_ADD   = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [ADDR_W:0]   RD_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   RD_TWO = {{(ADDR_W-1){1'b0}}, 2'b10};
    localparam logic [ADDR_W-1:0] WR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q;
    state_t            state_d;
    // Extra MSB on the read pointer keeps the end comparison from wrapping.
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   end_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              busy_q;
    logic [DATA_W-1:0] sum;
    logic [ADDR_W:0]   rd_plus1;
    logic [ADDR_W:0]   rd_plus2;
    logic              has_b;
    logic              accept;
    logic              empty_range;

    assign rd_plus1    = rd_ptr + RD_ONE;
    assign rd_plus2    = rd_ptr + RD_TWO;
    assign has_b       = (rd_plus1 <= end_q);
    assign accept      = (state_q == S_IDLE) && start_i;
    assign empty_range = (read_end_addr_i < read_start_addr_i);

    adder32 u_adder (
        .a_i   (a_q),
        .b_i   (b_q),
        .sum_o (sum)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = empty_range ? S_DONE : S_RD_A;
                end
            end
            S_RD_A:  state_d = S_RD_B;
            S_RD_B:  state_d = S_ADD;
            S_ADD:   state_d = S_WRITE;
            S_WRITE: state_d = (rd_plus2 > end_q) ? S_DONE : S_RD_A;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        done_o      = 1'b0;
        case (state_q)
            S_RD_A: begin
                mem_req_o  = 1'b1;
                mem_addr_o = rd_ptr[ADDR_W-1:0];
            end
            S_RD_B: begin
                // Odd-length tail: no B operand exists, so no read is issued.
                if (has_b) begin
                    mem_req_o  = 1'b1;
                    mem_addr_o = rd_plus1[ADDR_W-1:0];
                end
            end
            S_WRITE: begin
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = wr_ptr;
                mem_wdata_o = sum;
            end
            S_DONE: begin
                done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy_o = busy_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            end_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            busy_q <= 1'b0;
        end else begin
            busy_q <= (state_d == S_RD_A) || (state_d == S_RD_B) ||
                      (state_d == S_ADD)  || (state_d == S_WRITE);
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        rd_ptr <= {1'b0, read_start_addr_i};
                        wr_ptr <= write_start_addr_i;
                        end_q  <= {1'b0, read_end_addr_i};
                    end
                end
                S_RD_B: begin
                    a_q <= mem_rdata_i;
                end
                S_ADD: begin
                    b_q <= has_b ? mem_rdata_i : '0;
                end
                S_WRITE: begin
                    rd_ptr <= rd_plus2;
                    wr_ptr <= wr_ptr + WR_ONE;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CALC_SEQ_CARRY_FLAG_EN
    logic carry_q;

    // A wrapped sum is always smaller than either operand, so sum < a_q flags carry-out.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            carry_q <= 1'b0;
        end else if (accept) begin
            carry_q <= 1'b0;
        end else if ((state_q == S_WRITE) && (sum < a_q)) begin
            carry_q <= 1'b1;
        end
    end

    assign carry_o = carry_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif
endmodule

// File: tb/tb_calc_add_sequencer.sv
// Directed bench for calc_add_sequencer with a 1-cycle-latency SRAM model.
// Define CALC_SEQ_CARRY_FLAG_EN to also exercise the carry flag.
module tb_calc_add_sequencer;
    localparam int ADDR_W = 8;
    localparam int W      = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] rs = '0;
    logic [ADDR_W-1:0] re = '0;
    logic [ADDR_W-1:0] ws = '0;
    logic              busy;
    logic              done;
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [W-1:0]      wdata;
    logic [W-1:0]      rdata = '0;
`ifdef CALC_SEQ_CARRY_FLAG_EN
    logic              carry;
`endif

    logic [W-1:0]      mem [256];
    logic              ld_en = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [W-1:0]      ld_data = '0;
    int                n_reads = 0;
    int                n_writes = 0;
    int                checks = 0;
    int                failures = 0;
    logic [W-1:0]      exp_q[$];

    localparam logic [W-1:0] SENT = 32'hDEAD_BEEF;

    always #5 clk = ~clk;

    calc_add_sequencer #(.ADDR_W(ADDR_W)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .start_i            (start),
        .read_start_addr_i  (rs),
        .read_end_addr_i    (re),
        .write_start_addr_i (ws),
        .busy_o             (busy),
        .done_o             (done),
        .mem_req_o          (req),
        .mem_we_o           (we),
        .mem_addr_o         (addr),
        .mem_wdata_o        (wdata),
        .mem_rdata_i        (rdata)
`ifdef CALC_SEQ_CARRY_FLAG_EN
        ,
        .carry_o            (carry)
`endif
    );

    // SRAM model: read data returns one cycle after the request.
    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] = ld_data;
        if (req && !we) begin
            rdata <= mem[addr];
            n_reads = n_reads + 1;
        end
        if (req && we) begin
            mem[addr] = wdata;
            n_writes = n_writes + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic load(input logic [ADDR_W-1:0] a, input logic [W-1:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    // Returns observing cycle 1 (the first cycle after the start cycle).
    task automatic kick(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e,
                        input logic [ADDR_W-1:0] w);
        rs    = s;
        re    = e;
        ws    = w;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc      = 1;
        busy_cnt = 0;
        while (!done && cyc < 200) begin
            busy_cnt += int'(busy);
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL wait_done timeout after %0d cycles", cyc);
        end
    endtask

    task automatic test_reset();
        int req_seen;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, req, we, addr, wdata} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b req=%b we=%b addr=%h wdata=%h want all 0",
                     busy, done, req, we, addr, wdata);
        end
        rst = 1'b0;
        req_seen = 0;
        for (int i = 0; i < 20; i++) begin
            req_seen += int'(req);
            @(negedge clk);
        end
        checks++;
        if (req_seen != 0) begin
            failures++;
            $display("FAIL idle_no_req got %0d request cycles want 0", req_seen);
        end
        load(8'h00, 32'd1);
        load(8'h01, 32'd2);
        kick(8'h00, 8'h01, 8'hE0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, req, we, addr, wdata} !== '0) begin
            failures++;
            $display("FAIL async_reset got busy=%b done=%b req=%b we=%b addr=%h wdata=%h want all 0",
                     busy, done, req, we, addr, wdata);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_pair();
        int w0, r0;
        load(8'h00, 32'd5);
        load(8'h01, 32'd7);
        load(8'h10, SENT);
        w0 = n_writes;
        r0 = n_reads;
        kick(8'h00, 8'h01, 8'h10);
        for (int k = 1; k <= 6; k++) begin
            checks++;
            if (busy !== (k >= 1 && k <= 4) || done !== (k == 5)) begin
                failures++;
                $display("FAIL basic_timing cycle %0d got busy=%b done=%b want busy=%b done=%b",
                         k, busy, done, (k >= 1 && k <= 4), (k == 5));
            end
            @(negedge clk);
        end
        checks++;
        if (mem[8'h10] !== 32'd12) begin
            failures++;
            $display("FAIL basic_sum got %h want %h", mem[8'h10], 32'd12);
        end
        checks++;
        if (n_writes - w0 != 1 || n_reads - r0 != 2) begin
            failures++;
            $display("FAIL basic_accesses got writes=%0d reads=%0d want 1 and 2",
                     n_writes - w0, n_reads - r0);
        end
    endtask

    task automatic test_overflow();
        int cyc, bc;
        logic [W-1:0] e;
        load(8'h00, 32'hFFFF_FFFF);
        load(8'h01, 32'h0000_0001);
        load(8'h02, 32'h8000_0000);
        load(8'h03, 32'h8000_0000);
        load(8'h20, SENT);
        load(8'h21, SENT);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0000);
        kick(8'h00, 8'h03, 8'h20);
        wait_done(cyc, bc);
        checks++;
        if (cyc != 9 || bc != 8) begin
            failures++;
            $display("FAIL overflow_latency got done@%0d busy_cycles=%0d want 9 and 8", cyc, bc);
        end
`ifdef CALC_SEQ_CARRY_FLAG_EN
        checks++;
        if (carry !== 1'b1) begin
            failures++;
            $display("FAIL carry_set got %b want 1", carry);
        end
`endif
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (mem[8'h20 + i] !== e) begin
                failures++;
                $display("FAIL overflow_sum[%0d] got %h want %h", i, mem[8'h20 + i], e);
            end
        end
`ifdef CALC_SEQ_CARRY_FLAG_EN
        checks++;
        if (carry !== 1'b1) begin
            failures++;
            $display("FAIL carry_hold_idle got %b want 1", carry);
        end
`endif
        load(8'h30, 32'd1);
        load(8'h31, 32'd2);
        kick(8'h30, 8'h31, 8'h38);
        wait_done(cyc, bc);
        checks++;
        if (cyc != 5) begin
            failures++;
            $display("FAIL small_latency got done@%0d want 5", cyc);
        end
`ifdef CALC_SEQ_CARRY_FLAG_EN
        checks++;
        if (carry !== 1'b0) begin
            failures++;
            $display("FAIL carry_clear got %b want 0", carry);
        end
`endif
        @(negedge clk);
        checks++;
        if (mem[8'h38] !== 32'd3) begin
            failures++;
            $display("FAIL small_sum got %h want %h", mem[8'h38], 32'd3);
        end
    endtask

    task automatic test_odd_tail();
        int cyc, bc, w0, r0;
        load(8'h04, 32'd1);
        load(8'h05, 32'd2);
        load(8'h06, 32'd9);
        load(8'h07, 32'h77);
        load(8'h40, SENT);
        load(8'h41, SENT);
        w0 = n_writes;
        r0 = n_reads;
        kick(8'h04, 8'h06, 8'h40);
        wait_done(cyc, bc);
        checks++;
        if (cyc != 9) begin
            failures++;
            $display("FAIL odd_latency got done@%0d want 9", cyc);
        end
        @(negedge clk);
        checks++;
        if (mem[8'h40] !== 32'd3 || mem[8'h41] !== 32'd9) begin
            failures++;
            $display("FAIL odd_sums got %h %h want 3 9", mem[8'h40], mem[8'h41]);
        end
        checks++;
        if (n_reads - r0 != 3 || n_writes - w0 != 2) begin
            failures++;
            $display("FAIL odd_accesses got reads=%0d writes=%0d want 3 and 2",
                     n_reads - r0, n_writes - w0);
        end
    endtask

    task automatic test_empty();
        int cyc, bc, w0, r0;
        w0 = n_writes;
        r0 = n_reads;
        kick(8'h05, 8'h04, 8'h60);
        wait_done(cyc, bc);
        checks++;
        if (cyc != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL empty_done got done@%0d busy=%b want 1 and 0", cyc, busy);
        end
        @(negedge clk);
        checks++;
        if (n_reads != r0 || n_writes != w0) begin
            failures++;
            $display("FAIL empty_no_access got reads=%0d writes=%0d want 0 and 0",
                     n_reads - r0, n_writes - w0);
        end
    endtask

    task automatic test_wrap();
        int cyc, bc;
        load(8'h80, 32'd10);
        load(8'h81, 32'd20);
        load(8'h82, 32'd30);
        load(8'h83, 32'd40);
        load(8'hFF, SENT);
        load(8'h00, SENT);
        kick(8'h80, 8'h83, 8'hFF);
        wait_done(cyc, bc);
        @(negedge clk);
        checks++;
        if (mem[8'hFF] !== 32'd30 || mem[8'h00] !== 32'd70) begin
            failures++;
            $display("FAIL wrap_sums got ff=%h 00=%h want 1e 46", mem[8'hFF], mem[8'h00]);
        end
    endtask

    task automatic test_start_ignored();
        int cyc;
        load(8'h50, 32'd100);
        load(8'h51, 32'd200);
        load(8'h52, 32'd300);
        load(8'h53, 32'd400);
        load(8'h58, SENT);
        load(8'h59, SENT);
        load(8'h70, SENT);
        kick(8'h50, 8'h53, 8'h58);
        cyc = 1;
        while (!done && cyc < 200) begin
            if (cyc == 3) begin
                rs    = 8'h00;
                re    = 8'h00;
                ws    = 8'h70;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        checks++;
        if (cyc != 9) begin
            failures++;
            $display("FAIL ignored_latency got done@%0d want 9", cyc);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || req !== 1'b0) begin
            failures++;
            $display("FAIL ignored_no_restart got busy=%b req=%b want 0 0", busy, req);
        end
        checks++;
        if (mem[8'h58] !== 32'd300 || mem[8'h59] !== 32'd700 || mem[8'h70] !== SENT) begin
            failures++;
            $display("FAIL ignored_sums got %h %h %h want 12c 2bc deadbeef",
                     mem[8'h58], mem[8'h59], mem[8'h70]);
        end
    endtask

    task automatic test_reset_mid_job();
        int cyc, bc, w0, seen;
        for (int i = 0; i < 6; i++) load(8'h90 + 8'(i), 32'(i + 1));
        for (int i = 0; i < 3; i++) load(8'hA0 + 8'(i), SENT);
        w0 = n_writes;
        kick(8'h90, 8'h95, 8'hA0);
        repeat (3) @(negedge clk);
        checks++;
        if (we !== 1'b1 || req !== 1'b1) begin
            failures++;
            $display("FAIL midjob_in_write got req=%b we=%b want 1 1", req, we);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (req !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midjob_reset got req=%b busy=%b want 0 0", req, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            seen += int'(done) + int'(req);
            @(negedge clk);
        end
        checks++;
        if (seen != 0 || n_writes != w0 || mem[8'hA0] !== SENT) begin
            failures++;
            $display("FAIL midjob_abandon got activity=%0d writes=%0d memA0=%h want 0 0 deadbeef",
                     seen, n_writes - w0, mem[8'hA0]);
        end
        kick(8'h90, 8'h91, 8'hA2);
        wait_done(cyc, bc);
        @(negedge clk);
        checks++;
        if (cyc != 5 || mem[8'hA2] !== 32'd3) begin
            failures++;
            $display("FAIL midjob_restart got done@%0d sum=%h want 5 and 3", cyc, mem[8'hA2]);
        end
    endtask

    initial begin
        test_reset();
        test_basic_pair();
        test_overflow();
        test_odd_tail();
        test_empty();
        test_wrap();
        test_start_ignored();
        test_reset_mid_job();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
